// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-slot alarm controller.
package alarm_pkg;

  localparam int BCD_TIME_W = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_t;

  // A time is accepted only if every digit is decimal and it does not exceed 23:59:59.
  function automatic logic bcd_time_valid(input logic [BCD_TIME_W-1:0] t);
    logic ok;
    ok = (t <= 24'h235959);
    for (int d = 0; d < 6; d++) begin
      if (t[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/alarm_slot_bank.sv
// Alarm slot register file: validated writes, per-slot time comparators
// and the combinational read port.
module alarm_slot_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int SW         = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sec_pulse,
  input  logic                  alarm_enable,
  input  logic [BCD_TIME_W-1:0] cur_time,
  input  logic                  wr_en,
  input  logic [SW-1:0]         wr_slot,
  input  logic [BCD_TIME_W-1:0] wr_time,
  input  logic                  wr_slot_en,
  input  logic [SW-1:0]         rd_slot,
  output logic                  wr_accept,
  output logic [BCD_TIME_W-1:0] rd_time,
  output logic [NUM_ALARMS-1:0] slot_en,
  output logic [NUM_ALARMS-1:0] match
);

  localparam logic [SW:0] NUM_SLOTS = NUM_ALARMS[SW:0];

  logic [BCD_TIME_W-1:0] slot_time_r [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] slot_en_r;

  // Write qualification: legal slot index and a well-formed BCD time
  always_comb begin
    wr_accept = wr_en && bcd_time_valid(wr_time) && ({1'b0, wr_slot} < NUM_SLOTS);
  end

  // Slot storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) slot_time_r[i] <= '0;
      slot_en_r <= '0;
    end else if (wr_accept) begin
      slot_time_r[wr_slot] <= wr_time;
      slot_en_r[wr_slot]   <= wr_slot_en;
    end
  end

  // Per-slot comparators, qualified by the seconds tick, and the read mux
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match[i] = slot_en_r[i] && (slot_time_r[i] == cur_time) && sec_pulse && alarm_enable;
    end
    if ({1'b0, rd_slot} < NUM_SLOTS) rd_time = slot_time_r[rd_slot];
    else                             rd_time = '0;
  end

  assign slot_en = slot_en_r;

endmodule

// File: rtl/multi_alarm_controller.sv
// Multi-slot alarm controller: one ringing/snooze FSM shared by all slots,
// with a pending queue for matches that arrive during an active event.
module multi_alarm_controller
  import alarm_pkg::*;
#(
  parameter int  NUM_ALARMS       = 4,
  parameter int  SNOOZE_SEC       = 300,
  parameter int  RING_TIMEOUT_SEC = 60,
  parameter int  MAX_SNOOZES      = 3,
  localparam int SW  = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int NCW = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Sec_Pulse,
  input  logic [BCD_TIME_W-1:0] i_Time,
  input  logic                  i_Alarm_Enable,
  input  logic                  i_Wr_En,
  input  logic [SW-1:0]         i_Wr_Slot,
  input  logic [BCD_TIME_W-1:0] i_Wr_Time,
  input  logic                  i_Wr_Slot_En,
  input  logic                  i_Snooze,
  input  logic                  i_Dismiss,
  input  logic [SW-1:0]         i_Rd_Slot,
  output logic [BCD_TIME_W-1:0] o_Rd_Time,
  output logic [NUM_ALARMS-1:0] o_Slot_En,
  output logic                  o_Alarm_On,
  output logic                  o_Snoozed,
  output logic [SW-1:0]         o_Active_Slot,
  output logic [NUM_ALARMS-1:0] o_Pending,
  output logic [NCW-1:0]        o_Snooze_Count
);

  localparam int RCW = $clog2(RING_TIMEOUT_SEC + 1);
  localparam int SCW = $clog2(SNOOZE_SEC + 1);
  localparam logic [RCW-1:0] RING_LAST   = RCW'(RING_TIMEOUT_SEC - 1);
  localparam logic [SCW-1:0] SNOOZE_LOAD = SCW'(SNOOZE_SEC);
  localparam logic [NCW-1:0] SNOOZE_MAX  = NCW'(MAX_SNOOZES);

  alarm_state_t          state_r;
  logic [SW-1:0]         active_r;
  logic [NUM_ALARMS-1:0] pending_r;
  logic [RCW-1:0]        ring_cnt_r;
  logic [SCW-1:0]        snooze_tmr_r;
  logic [NCW-1:0]        snooze_cnt_r;
  logic                  alarm_on_r;
  logic                  snoozed_r;

  logic [NUM_ALARMS-1:0] match_s;
  logic [NUM_ALARMS-1:0] clear_mask_s;
  logic [NUM_ALARMS-1:0] queued_s;
  logic [SW-1:0]         first_match_s;
  logic [SW-1:0]         first_queued_s;
  logic                  wr_accept_s;
  logic                  wr_kill_s;
  logic                  snooze_ok_s;
  logic                  end_s;

  alarm_slot_bank #(
    .NUM_ALARMS (NUM_ALARMS),
    .SW         (SW)
  ) u_bank (
    .clk          (i_Clk),
    .rst_n        (i_Reset),
    .sec_pulse    (i_Sec_Pulse),
    .alarm_enable (i_Alarm_Enable),
    .cur_time     (i_Time),
    .wr_en        (i_Wr_En),
    .wr_slot      (i_Wr_Slot),
    .wr_time      (i_Wr_Time),
    .wr_slot_en   (i_Wr_Slot_En),
    .rd_slot      (i_Rd_Slot),
    .wr_accept    (wr_accept_s),
    .rd_time      (o_Rd_Time),
    .slot_en      (o_Slot_En),
    .match        (match_s)
  );

  // Event-control decode; a disabling write counts as a dismiss for the active slot
  always_comb begin
    if (wr_accept_s && !i_Wr_Slot_En) clear_mask_s = NUM_ALARMS'(1) << i_Wr_Slot;
    else                              clear_mask_s = '0;
    wr_kill_s      = (state_r != IDLE) && (clear_mask_s != '0) && (i_Wr_Slot == active_r);
    queued_s       = (pending_r | match_s) & ~clear_mask_s;
    first_match_s  = SW'(lowest_set(8'(match_s)));
    first_queued_s = SW'(lowest_set(8'(queued_s)));
    snooze_ok_s    = i_Snooze && (snooze_cnt_r < SNOOZE_MAX);
    case (state_r)
      RINGING: begin
        if (i_Dismiss || wr_kill_s) end_s = 1'b1;
        else if (snooze_ok_s)       end_s = 1'b0;
        else                        end_s = i_Sec_Pulse && (ring_cnt_r == RING_LAST);
      end
      SNOOZED: end_s = i_Dismiss || wr_kill_s;
      default: end_s = 1'b0;
    endcase
  end

  // Ring/snooze FSM with counters, pending queue and registered outputs
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_r      <= IDLE;
      active_r     <= '0;
      pending_r    <= '0;
      ring_cnt_r   <= '0;
      snooze_tmr_r <= '0;
      snooze_cnt_r <= '0;
      alarm_on_r   <= 1'b0;
      snoozed_r    <= 1'b0;
    end else if (!i_Alarm_Enable || (end_s && queued_s == '0)) begin
      state_r      <= IDLE;
      active_r     <= '0;
      pending_r    <= '0;
      ring_cnt_r   <= '0;
      snooze_tmr_r <= '0;
      snooze_cnt_r <= '0;
      alarm_on_r   <= 1'b0;
      snoozed_r    <= 1'b0;
    end else if (end_s) begin
      state_r      <= RINGING;
      active_r     <= first_queued_s;
      pending_r    <= queued_s & ~(NUM_ALARMS'(1) << first_queued_s);
      ring_cnt_r   <= '0;
      snooze_tmr_r <= '0;
      snooze_cnt_r <= '0;
      alarm_on_r   <= 1'b1;
      snoozed_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (match_s != '0) begin
            state_r      <= RINGING;
            active_r     <= first_match_s;
            pending_r    <= match_s & ~(NUM_ALARMS'(1) << first_match_s) & ~clear_mask_s;
            ring_cnt_r   <= '0;
            snooze_tmr_r <= '0;
            snooze_cnt_r <= '0;
            alarm_on_r   <= 1'b1;
            snoozed_r    <= 1'b0;
          end
        end
        RINGING: begin
          pending_r <= queued_s;
          if (snooze_ok_s) begin
            state_r      <= SNOOZED;
            snooze_tmr_r <= SNOOZE_LOAD;
            snooze_cnt_r <= snooze_cnt_r + NCW'(1);
            alarm_on_r   <= 1'b0;
            snoozed_r    <= 1'b1;
          end else if (i_Sec_Pulse) begin
            ring_cnt_r <= ring_cnt_r + RCW'(1);
          end
        end
        SNOOZED: begin
          pending_r <= queued_s;
          if (i_Sec_Pulse) begin
            if (snooze_tmr_r == SCW'(1)) begin
              state_r    <= RINGING;
              ring_cnt_r <= '0;
              alarm_on_r <= 1'b1;
              snoozed_r  <= 1'b0;
            end else begin
              snooze_tmr_r <= snooze_tmr_r - SCW'(1);
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          active_r   <= '0;
          pending_r  <= '0;
          alarm_on_r <= 1'b0;
          snoozed_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Alarm_On     = alarm_on_r;
  assign o_Snoozed      = snoozed_r;
  assign o_Active_Slot  = active_r;
  assign o_Pending      = pending_r;
  assign o_Snooze_Count = snooze_cnt_r;

endmodule

// File: tb/tb_multi_alarm_controller.sv
// Self-checking bench for multi_alarm_controller: directed scenarios plus
// randomized traffic checked against an event-level reference model.
module tb_multi_alarm_controller;

  localparam int NA  = 4;
  localparam int SNZ = 2;
  localparam int RTO = 3;
  localparam int MXS = 1;

  logic        clk = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Sec_Pulse = 1'b0;
  logic [23:0] i_Time = 24'h0;
  logic        i_Alarm_Enable = 1'b1;
  logic        i_Wr_En = 1'b0;
  logic [1:0]  i_Wr_Slot = 2'd0;
  logic [23:0] i_Wr_Time = 24'h0;
  logic        i_Wr_Slot_En = 1'b0;
  logic        i_Snooze = 1'b0;
  logic        i_Dismiss = 1'b0;
  logic [1:0]  i_Rd_Slot = 2'd0;
  logic [23:0] o_Rd_Time;
  logic [3:0]  o_Slot_En;
  logic        o_Alarm_On;
  logic        o_Snoozed;
  logic [1:0]  o_Active_Slot;
  logic [3:0]  o_Pending;
  logic [0:0]  o_Snooze_Count;

  int tests_run = 0;
  int fails = 0;

  multi_alarm_controller #(
    .NUM_ALARMS(NA), .SNOOZE_SEC(SNZ), .RING_TIMEOUT_SEC(RTO), .MAX_SNOOZES(MXS)
  ) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Sec_Pulse(i_Sec_Pulse), .i_Time(i_Time),
    .i_Alarm_Enable(i_Alarm_Enable), .i_Wr_En(i_Wr_En), .i_Wr_Slot(i_Wr_Slot),
    .i_Wr_Time(i_Wr_Time), .i_Wr_Slot_En(i_Wr_Slot_En), .i_Snooze(i_Snooze),
    .i_Dismiss(i_Dismiss), .i_Rd_Slot(i_Rd_Slot), .o_Rd_Time(o_Rd_Time),
    .o_Slot_En(o_Slot_En), .o_Alarm_On(o_Alarm_On), .o_Snoozed(o_Snoozed),
    .o_Active_Slot(o_Active_Slot), .o_Pending(o_Pending), .o_Snooze_Count(o_Snooze_Count)
  );

  always #100 clk = ~clk;

  // Reference model: event-level view (0 idle, 1 ringing, 2 snoozed)
  int          m_state, m_active, m_ring_secs, m_snooze_left, m_snoozes;
  bit          m_pend [NA];
  logic [23:0] m_time [NA];
  bit          m_en [NA];

  function automatic bit time_ok(input logic [23:0] t);
    int hh, mm, ss;
    for (int k = 0; k < 6; k++) if (((t >> (4 * k)) & 24'hF) > 24'd9) return 1'b0;
    hh = int'(t[23:20]) * 10 + int'(t[19:16]);
    mm = int'(t[15:12]) * 10 + int'(t[11:8]);
    ss = int'(t[7:4]) * 10 + int'(t[3:0]);
    return (hh * 10000 + mm * 100 + ss) <= 235959;
  endfunction

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] v = 4'b0;
    for (int i = 0; i < NA; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [3:0] m_en_vec();
    logic [3:0] v = 4'b0;
    for (int i = 0; i < NA; i++) v[i] = m_en[i];
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_active = 0; m_ring_secs = 0; m_snooze_left = 0; m_snoozes = 0;
    for (int i = 0; i < NA; i++) begin m_pend[i] = 0; m_time[i] = 24'h0; m_en[i] = 0; end
  endtask

  task automatic model_new_event(input int slot);
    m_state = 1; m_active = slot; m_ring_secs = 0; m_snooze_left = 0; m_snoozes = 0;
  endtask

  task automatic model_apply();
    bit hit [NA];
    bit wr_ok, wr_off, ended;
    int w, first;
    w      = int'(i_Wr_Slot);
    wr_ok  = i_Wr_En && time_ok(i_Wr_Time);
    wr_off = wr_ok && !i_Wr_Slot_En;
    for (int i = 0; i < NA; i++)
      hit[i] = m_en[i] && (m_time[i] == i_Time) && i_Sec_Pulse && i_Alarm_Enable;
    if (!i_Alarm_Enable) begin
      m_state = 0; m_active = 0; m_ring_secs = 0; m_snooze_left = 0; m_snoozes = 0;
      for (int i = 0; i < NA; i++) m_pend[i] = 0;
    end else if (m_state == 0) begin
      first = -1;
      for (int i = NA - 1; i >= 0; i--) if (hit[i]) first = i;
      if (first >= 0) begin
        for (int i = 0; i < NA; i++) m_pend[i] = hit[i] && (i != first);
        if (wr_off) m_pend[w] = 0;
        model_new_event(first);
      end
    end else begin
      for (int i = 0; i < NA; i++) if (hit[i]) m_pend[i] = 1;
      if (wr_off) m_pend[w] = 0;
      ended = i_Dismiss || (wr_off && w == m_active);
      if (!ended && m_state == 1) begin
        if (i_Snooze && m_snoozes < MXS) begin
          m_state = 2; m_snooze_left = SNZ; m_snoozes++;
        end else if (i_Sec_Pulse) begin
          if (m_ring_secs + 1 >= RTO) ended = 1;
          else m_ring_secs++;
        end
      end else if (!ended && i_Sec_Pulse) begin
        if (m_snooze_left == 1) begin m_state = 1; m_ring_secs = 0; end
        else m_snooze_left--;
      end
      if (ended) begin
        first = -1;
        for (int i = NA - 1; i >= 0; i--) if (m_pend[i]) first = i;
        if (first >= 0) begin m_pend[first] = 0; model_new_event(first); end
        else begin m_state = 0; m_active = 0; m_ring_secs = 0; m_snoozes = 0; end
      end
    end
    if (wr_ok) begin m_time[w] = i_Wr_Time; m_en[w] = i_Wr_Slot_En; end
  endtask

  // Stimulus helpers: inputs change 1 time unit after the rising edge
  task automatic clk_step();
    model_apply();
    @(posedge clk);
    #1;
    i_Sec_Pulse = 1'b0; i_Snooze = 1'b0; i_Dismiss = 1'b0; i_Wr_En = 1'b0;
  endtask

  task automatic do_tick(input logic [23:0] t);
    i_Time = t; i_Sec_Pulse = 1'b1; clk_step();
  endtask

  task automatic do_write(input int slot, input logic [23:0] t, input bit en);
    i_Wr_Slot = 2'(slot); i_Wr_Time = t; i_Wr_Slot_En = en; i_Wr_En = 1'b1; clk_step();
  endtask

  task automatic do_snooze();
    i_Snooze = 1'b1; clk_step();
  endtask

  task automatic do_dismiss();
    i_Dismiss = 1'b1; clk_step();
  endtask

  task automatic test_reset();
    model_reset();
    i_Reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_Reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++; if (o_Alarm_On !== 1'b0) begin fails++; $display("FAIL reset_alarm_on: got %0b want 0", o_Alarm_On); end
    tests_run++; if (o_Snoozed !== 1'b0) begin fails++; $display("FAIL reset_snoozed: got %0b want 0", o_Snoozed); end
    tests_run++; if (o_Active_Slot !== 2'd0) begin fails++; $display("FAIL reset_active: got %0d want 0", o_Active_Slot); end
    tests_run++; if (o_Pending !== 4'b0) begin fails++; $display("FAIL reset_pending: got %b want 0000", o_Pending); end
    tests_run++; if (o_Snooze_Count !== 1'b0) begin fails++; $display("FAIL reset_snooze_count: got %0d want 0", o_Snooze_Count); end
    tests_run++; if (o_Slot_En !== 4'b0) begin fails++; $display("FAIL reset_slot_en: got %b want 0000", o_Slot_En); end
    for (int s = 0; s < NA; s++) begin
      i_Rd_Slot = 2'(s);
      #1;
      tests_run++; if (o_Rd_Time !== 24'h0) begin fails++; $display("FAIL reset_rd_time[%0d]: got %h want 000000", s, o_Rd_Time); end
    end
  endtask

  task automatic test_timeout();
    do_write(0, 24'h070000, 1'b1);
    do_tick(24'h070000);
    tests_run++; if (o_Alarm_On !== 1'b1) begin fails++; $display("FAIL ring_on: got %0b want 1", o_Alarm_On); end
    tests_run++; if (o_Active_Slot !== 2'd0) begin fails++; $display("FAIL ring_active: got %0d want 0", o_Active_Slot); end
    do_tick(24'h070001);
    do_tick(24'h070002);
    tests_run++; if (o_Alarm_On !== 1'b1) begin fails++; $display("FAIL ring_before_timeout: got %0b want 1", o_Alarm_On); end
    do_tick(24'h070003);
    tests_run++; if (o_Alarm_On !== 1'b0) begin fails++; $display("FAIL ring_timeout: got %0b want 0", o_Alarm_On); end
  endtask

  task automatic test_snooze();
    do_write(2, 24'h061500, 1'b1);
    do_tick(24'h061500);
    tests_run++; if (o_Active_Slot !== 2'd2) begin fails++; $display("FAIL snz_active: got %0d want 2", o_Active_Slot); end
    do_snooze();
    tests_run++; if (o_Snoozed !== 1'b1 || o_Alarm_On !== 1'b0) begin fails++; $display("FAIL snz_enter: got snoozed=%0b on=%0b want 1/0", o_Snoozed, o_Alarm_On); end
    tests_run++; if (o_Snooze_Count !== 1'b1) begin fails++; $display("FAIL snz_count: got %0d want 1", o_Snooze_Count); end
    do_tick(24'h061501);
    tests_run++; if (o_Snoozed !== 1'b1) begin fails++; $display("FAIL snz_hold: got %0b want 1", o_Snoozed); end
    do_tick(24'h061502);
    tests_run++; if (o_Alarm_On !== 1'b1 || o_Snoozed !== 1'b0) begin fails++; $display("FAIL snz_rering: got on=%0b snoozed=%0b want 1/0", o_Alarm_On, o_Snoozed); end
    do_snooze();
    tests_run++; if (o_Alarm_On !== 1'b1 || o_Snoozed !== 1'b0) begin fails++; $display("FAIL snz_limit: got on=%0b snoozed=%0b want 1/0", o_Alarm_On, o_Snoozed); end
    do_dismiss();
    tests_run++; if (o_Alarm_On !== 1'b0 || o_Snooze_Count !== 1'b0) begin fails++; $display("FAIL snz_dismiss: got on=%0b count=%0d want 0/0", o_Alarm_On, o_Snooze_Count); end
  endtask

  task automatic test_queue();
    do_write(1, 24'h123015, 1'b1);
    do_write(3, 24'h123015, 1'b1);
    do_tick(24'h123015);
    tests_run++; if (o_Active_Slot !== 2'd1) begin fails++; $display("FAIL queue_active: got %0d want 1", o_Active_Slot); end
    tests_run++; if (o_Pending !== 4'b1000) begin fails++; $display("FAIL queue_pending: got %b want 1000", o_Pending); end
    do_dismiss();
    tests_run++; if (o_Active_Slot !== 2'd3 || o_Pending !== 4'b0000) begin fails++; $display("FAIL queue_handoff: got active=%0d pending=%b want 3/0000", o_Active_Slot, o_Pending); end
    tests_run++; if (o_Alarm_On !== 1'b1) begin fails++; $display("FAIL queue_handoff_on: got %0b want 1", o_Alarm_On); end
    do_dismiss();
    tests_run++; if (o_Alarm_On !== 1'b0) begin fails++; $display("FAIL queue_end: got %0b want 0", o_Alarm_On); end
  endtask

  task automatic test_precedence();
    do_tick(24'h070000);
    i_Snooze = 1'b1; i_Dismiss = 1'b1; clk_step();
    tests_run++; if (o_Alarm_On !== 1'b0 || o_Snoozed !== 1'b0) begin fails++; $display("FAIL prec_dismiss_over_snooze: got on=%0b snoozed=%0b want 0/0", o_Alarm_On, o_Snoozed); end
    do_tick(24'h070000);
    do_snooze();
    tests_run++; if (o_Snoozed !== 1'b1) begin fails++; $display("FAIL prec_snoozed: got %0b want 1", o_Snoozed); end
    do_write(0, 24'h070000, 1'b0);
    tests_run++; if (o_Snoozed !== 1'b0 || o_Alarm_On !== 1'b0 || o_Slot_En[0] !== 1'b0) begin fails++; $display("FAIL prec_write_kill: got snoozed=%0b on=%0b en0=%0b want 0/0/0", o_Snoozed, o_Alarm_On, o_Slot_En[0]); end
  endtask

  task automatic test_master();
    do_tick(24'h123015);
    tests_run++; if (o_Pending !== 4'b1000) begin fails++; $display("FAIL master_pre_pending: got %b want 1000", o_Pending); end
    i_Alarm_Enable = 1'b0; clk_step();
    tests_run++; if (o_Alarm_On !== 1'b0 || o_Pending !== 4'b0000) begin fails++; $display("FAIL master_off: got on=%0b pending=%b want 0/0000", o_Alarm_On, o_Pending); end
    tests_run++; if (o_Slot_En !== 4'b1110) begin fails++; $display("FAIL master_slots_kept: got %b want 1110", o_Slot_En); end
    i_Rd_Slot = 2'd1; #1;
    tests_run++; if (o_Rd_Time !== 24'h123015) begin fails++; $display("FAIL master_rd: got %h want 123015", o_Rd_Time); end
    do_tick(24'h123015);
    tests_run++; if (o_Alarm_On !== 1'b0) begin fails++; $display("FAIL master_no_ring: got %0b want 0", o_Alarm_On); end
    i_Alarm_Enable = 1'b1; clk_step();
  endtask

  task automatic test_write_validation();
    i_Rd_Slot = 2'd2; #1;
    tests_run++; if (o_Rd_Time !== 24'h061500) begin fails++; $display("FAIL wv_prior: got %h want 061500", o_Rd_Time); end
    do_write(2, 24'h240000, 1'b0);
    tests_run++; if (o_Rd_Time !== 24'h061500 || o_Slot_En[2] !== 1'b1) begin fails++; $display("FAIL wv_hour24: got %h en=%0b want 061500/1", o_Rd_Time, o_Slot_En[2]); end
    do_write(2, 24'h126A00, 1'b0);
    tests_run++; if (o_Rd_Time !== 24'h061500 || o_Slot_En[2] !== 1'b1) begin fails++; $display("FAIL wv_digitA: got %h en=%0b want 061500/1", o_Rd_Time, o_Slot_En[2]); end
  endtask

  task automatic test_random();
    logic [23:0] pool [4] = '{24'h070000, 24'h123015, 24'h061500, 24'h235959};
    logic [23:0] bad  [3] = '{24'h240000, 24'h126A00, 24'h235960};
    for (int n = 0; n < 400; n++) begin
      i_Rd_Slot = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 40) begin
        i_Sec_Pulse = 1'b1;
        i_Time = pool[$urandom_range(0, 3)];
      end else if ($urandom_range(0, 99) < 25) begin
        i_Wr_En = 1'b1;
        i_Wr_Slot = 2'($urandom_range(0, 3));
        i_Wr_Time = ($urandom_range(0, 9) == 0) ? bad[$urandom_range(0, 2)] : pool[$urandom_range(0, 3)];
        i_Wr_Slot_En = ($urandom_range(0, 9) < 8);
      end
      i_Snooze = ($urandom_range(0, 99) < 15);
      i_Dismiss = ($urandom_range(0, 99) < 6);
      i_Alarm_Enable = ($urandom_range(0, 99) >= 3);
      clk_step();
      tests_run++; if (o_Alarm_On !== (m_state == 1)) begin fails++; $display("FAIL rnd_alarm_on[%0d]: got %0b want %0b", n, o_Alarm_On, m_state == 1); end
      tests_run++; if (o_Snoozed !== (m_state == 2)) begin fails++; $display("FAIL rnd_snoozed[%0d]: got %0b want %0b", n, o_Snoozed, m_state == 2); end
      tests_run++; if (o_Active_Slot !== 2'(m_active)) begin fails++; $display("FAIL rnd_active[%0d]: got %0d want %0d", n, o_Active_Slot, m_active); end
      tests_run++; if (o_Pending !== m_pend_vec()) begin fails++; $display("FAIL rnd_pending[%0d]: got %b want %b", n, o_Pending, m_pend_vec()); end
      tests_run++; if (o_Snooze_Count !== 1'(m_snoozes)) begin fails++; $display("FAIL rnd_snooze_count[%0d]: got %0d want %0d", n, o_Snooze_Count, m_snoozes); end
      tests_run++; if (o_Slot_En !== m_en_vec()) begin fails++; $display("FAIL rnd_slot_en[%0d]: got %b want %b", n, o_Slot_En, m_en_vec()); end
      tests_run++; if (o_Rd_Time !== m_time[i_Rd_Slot]) begin fails++; $display("FAIL rnd_rd_time[%0d]: got %h want %h", n, o_Rd_Time, m_time[i_Rd_Slot]); end
    end
    i_Alarm_Enable = 1'b1;
  endtask

  task automatic test_async_reset();
    i_Alarm_Enable = 1'b0; clk_step();
    i_Alarm_Enable = 1'b1;
    do_write(2, 24'h061500, 1'b1);
    do_tick(24'h061500);
    do_snooze();
    tests_run++; if (o_Snoozed !== 1'b1) begin fails++; $display("FAIL ar_snoozed: got %0b want 1", o_Snoozed); end
    i_Rd_Slot = 2'd2;
    #50;
    i_Reset = 1'b0;
    #1;
    tests_run++; if (o_Snoozed !== 1'b0 || o_Alarm_On !== 1'b0 || o_Snooze_Count !== 1'b0) begin fails++; $display("FAIL ar_state: got snoozed=%0b on=%0b count=%0d want 0/0/0", o_Snoozed, o_Alarm_On, o_Snooze_Count); end
    tests_run++; if (o_Active_Slot !== 2'd0 || o_Pending !== 4'b0) begin fails++; $display("FAIL ar_active_pending: got %0d/%b want 0/0000", o_Active_Slot, o_Pending); end
    tests_run++; if (o_Slot_En !== 4'b0 || o_Rd_Time !== 24'h0) begin fails++; $display("FAIL ar_slots: got en=%b rd=%h want 0000/000000", o_Slot_En, o_Rd_Time); end
    model_reset();
    #50;
    i_Reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++; if (o_Slot_En !== 4'b0 || o_Alarm_On !== 1'b0) begin fails++; $display("FAIL ar_release: got en=%b on=%0b want 0000/0", o_Slot_En, o_Alarm_On); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_snooze();
    test_queue();
    test_precedence();
    test_master();
    test_write_validation();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
